// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command bridge: FSM state codes,
// command opcodes and response bytes.
// Imported by the bridge top and by its response queue.
package uart_cmd_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_GET_ADDR  = 3'd1;
  localparam logic [2:0] ST_GET_DATA  = 3'd2;
  localparam logic [2:0] ST_BUS       = 3'd3;
  localparam logic [2:0] ST_SEND      = 3'd4;
  localparam logic [2:0] ST_SEND_WAIT = 3'd5;

  localparam logic [7:0] OP_WR   = 8'h57;  // 'W'
  localparam logic [7:0] OP_RD   = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h3F;  // '?'

endpackage

// File: rtl/uart_cmd_txq.sv
// Response queue: holds up to DATA_BYTES reply bytes and sends them MSB first.
// One byte per SEND/SEND_WAIT pair, i.e. at most one wr_uart every 2 cycles.
// Waits in SEND while tx_full = 1; the dead cycle covers the tx_full rise latency.
module uart_cmd_txq
  import uart_cmd_pkg::*;
#(
  parameter int DATA_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [8*DATA_BYTES-1:0] load_data,
  input  logic [7:0]              load_count,
  input  logic                    tx_full,
  output logic [7:0]              wr_data,
  output logic                    wr_uart,
  output logic                    done
);

  localparam int DW = 8 * DATA_BYTES;

  logic [2:0]    phase;
  logic [DW-1:0] shreg;
  logic [7:0]    count;

  // Last dead cycle with nothing left: the owner returns to IDLE on this edge.
  assign done = (phase == ST_SEND_WAIT) && (count == 8'd0);

  // Load, then alternate SEND (emit top byte when tx is free) and SEND_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= ST_IDLE;
      shreg   <= '0;
      count   <= 8'd0;
      wr_data <= 8'd0;
      wr_uart <= 1'b0;
    end else begin
      wr_uart <= 1'b0;
      case (phase)
        ST_IDLE: begin
          if (load) begin
            shreg <= load_data;
            count <= load_count;
            phase <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!tx_full) begin
            wr_data <= shreg[DW-1 -: 8];
            wr_uart <= 1'b1;
            shreg   <= shreg << 8;
            count   <= count - 8'd1;
            phase   <= ST_SEND_WAIT;
          end
        end
        ST_SEND_WAIT: phase <= (count != 8'd0) ? ST_SEND : ST_IDLE;
        default:      phase <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_bridge.sv
// UART command bridge: decodes 'W'/'R' byte commands into req/ack bus cycles.
// Latency: bus request one cycle after the last command byte; reply after ack.
// Consumes at most one byte every 2 cycles; bytes arriving while busy stay in the UART.
module uart_cmd_bridge
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_BYTES  = 3,
  parameter int DATA_BYTES  = 2,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rd_data,
  input  logic                    rx_empty,
  output logic                    rd_uart,
  output logic [7:0]              wr_data,
  output logic                    wr_uart,
  input  logic                    tx_full,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [8*ADDR_BYTES-1:0] bus_addr,
  output logic [8*DATA_BYTES-1:0] bus_wdata,
  input  logic [8*DATA_BYTES-1:0] bus_rdata,
  input  logic                    bus_ack,
  output logic                    busy,
  output logic                    err_pulse
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYC);

  logic [2:0]    state;
  logic [7:0]    bcnt;
  logic [TW-1:0] tcnt;
  logic          take;
  logic          load;
  logic [DW-1:0] load_data;
  logic [7:0]    load_count;
  logic          tx_done;

  // A byte is taken only in receiving states, and never in the cycle right
  // after a take, because rx_empty has not yet reflected that pop.
  assign take = ((state == ST_IDLE) || (state == ST_GET_ADDR) || (state == ST_GET_DATA))
                && !rx_empty && !rd_uart;

  // Select what the response queue is loaded with: '?', 'K' or the read data.
  always_comb begin
    load       = 1'b0;
    load_data  = '0;
    load_count = 8'd1;
    if ((state == ST_IDLE) && take && (rd_data != OP_WR) && (rd_data != OP_RD)) begin
      load      = 1'b1;
      load_data = DW'(RSP_ERR) << (DW - 8);
    end else if ((state == ST_BUS) && bus_req && bus_ack) begin
      load = 1'b1;
      if (bus_we) begin
        load_data = DW'(RSP_OK) << (DW - 8);
      end else begin
        load_data  = bus_rdata;
        load_count = 8'(DATA_BYTES);
      end
    end
  end

  // Command FSM: byte intake, address/data assembly, timeout and bus handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bcnt      <= 8'd0;
      tcnt      <= '0;
      rd_uart   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      busy      <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      rd_uart   <= take;
      err_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            busy <= 1'b1;
            if ((rd_data == OP_WR) || (rd_data == OP_RD)) begin
              bus_we <= (rd_data == OP_WR);
              bcnt   <= 8'd0;
              tcnt   <= '0;
              state  <= ST_GET_ADDR;
            end else begin
              err_pulse <= 1'b1;
              state     <= ST_SEND;
            end
          end
        end
        ST_GET_ADDR, ST_GET_DATA: begin
          if (take) begin
            tcnt <= '0;
            bcnt <= bcnt + 8'd1;
            if (state == ST_GET_ADDR) begin
              bus_addr <= (bus_addr << 8) | AW'(rd_data);
              if (bcnt == 8'(ADDR_BYTES - 1)) begin
                bcnt  <= 8'd0;
                state <= bus_we ? ST_GET_DATA : ST_BUS;
              end
            end else begin
              bus_wdata <= (bus_wdata << 8) | DW'(rd_data);
              if (bcnt == 8'(DATA_BYTES - 1)) begin
                bcnt  <= 8'd0;
                state <= ST_BUS;
              end
            end
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            // Host went silent mid-command: drop it without a reply.
            err_pulse <= 1'b1;
            tcnt      <= '0;
            bcnt      <= 8'd0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_BUS: begin
          if (!bus_req) begin
            bus_req <= 1'b1;
          end else if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_done) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  uart_cmd_txq #(
    .DATA_BYTES(DATA_BYTES)
  ) u_txq (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_data  (load_data),
    .load_count (load_count),
    .tx_full    (tx_full),
    .wr_data    (wr_data),
    .wr_uart    (wr_uart),
    .done       (tx_done)
  );

endmodule

// File: doc/uart_cmd_bridge.md
Name: uart_cmd_bridge

Overview:
Host-side command engine that connects to the user side of the UART wrapper. It consumes received bytes through the rd_data / rx_empty / rd_uart handshake and decodes a byte-oriented read/write command protocol. Each decoded command becomes one transaction on a simple req/ack memory bus, for example an SDRAM or VGA register port. The block then returns response bytes through the wr_data / wr_uart / tx_full handshake.

Parameters:
ADDR_BYTES, 3, number of address bytes per command, sent MSB first; bus_addr width = 8*ADDR_BYTES.
DATA_BYTES, 2, number of data bytes per word, sent MSB first; bus data width = 8*DATA_BYTES.
TIMEOUT_CYC, 50000000, maximum idle clocks between bytes inside one command before it is aborted; must be >= 2.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst_n  in  1  asynchronous active-low reset.
rd_data  in  8  received byte from the UART; valid while rx_empty = 0.
rx_empty  in  1  1 = no received byte pending.
rd_uart  out  1  one-cycle pulse that consumes rd_data.
wr_data  out  8  byte to transmit; valid in the cycle wr_uart = 1.
wr_uart  out  1  one-cycle pulse that starts a transmit.
tx_full  in  1  1 = transmitter busy; rises the cycle after wr_uart.
bus_req  out  1  bus request, held until acknowledged.
bus_we  out  1  1 = write, 0 = read; stable while bus_req = 1.
bus_addr  out  8*ADDR_BYTES  transaction address; stable while bus_req = 1.
bus_wdata  out  8*DATA_BYTES  write data; stable while bus_req = 1.
bus_rdata  in  8*DATA_BYTES  read data; sampled in the cycle bus_ack = 1.
bus_ack  in  1  single-cycle completion strobe from the bus.
busy  out  1  1 whenever the state is not IDLE.
err_pulse  out  1  one-cycle pulse on a bad opcode or a timeout.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State goes to IDLE.
  - All outputs are 0, all counters are 0, all shift registers are 0.
  - Reset mid-command or mid-bus-cycle drops bus_req immediately; no response byte is sent.
- All outputs are registered.
- Byte intake rule: when rx_empty = 0 in a receiving state, pulse rd_uart for one cycle and latch rd_data in that same cycle. rx_empty is not re-sampled in the following cycle.
- Command protocol:
  - Write: 0x57 'W', then ADDR_BYTES address bytes, then DATA_BYTES data bytes. The bus write completes, then the block replies 0x4B 'K'.
  - Read: 0x52 'R', then ADDR_BYTES address bytes. The bus read completes, then the block replies DATA_BYTES bytes of bus_rdata, MSB first.
  - Any other first byte: reply 0x3F '?', pulse err_pulse, return to IDLE.
- State machine:
  - IDLE: on a byte, decode the opcode. 'W' or 'R' sets the we flag and goes to GET_ADDR. Any other byte loads '?' and goes to SEND.
  - GET_ADDR: shift the address left by 8 per byte. After the ADDR_BYTES-th byte, go to GET_DATA if we = 1, else to BUS.
  - GET_DATA: shift the write data the same way. After the DATA_BYTES-th byte, go to BUS.
  - BUS: bus_req = 1 starting the cycle after entry.
    - In the cycle bus_ack = 1 (including the first req cycle), capture bus_rdata and clear bus_req at that edge.
    - Write: load 'K', count = 1. Read: load the read data, count = DATA_BYTES. Go to SEND.
    - bus_ack while bus_req = 0 is ignored.
  - SEND: when tx_full = 0, drive wr_data = top byte of the shift register and pulse wr_uart, shift left by 8, decrement count, go to SEND_WAIT.
  - SEND_WAIT: one mandatory dead cycle, which covers the tx_full rise latency. Then go to SEND if count != 0, else to IDLE.
- Timeout:
  - The counter clears on every consumed byte and on entry to GET_ADDR.
  - It increments each cycle in GET_ADDR or GET_DATA while no byte is taken.
  - At TIMEOUT_CYC-1: pulse err_pulse, go to IDLE, discard the partial command, send no response.
  - There is no timeout in BUS or SEND.
- Bytes that arrive during BUS / SEND / SEND_WAIT stay pending in the UART and are not consumed. They are handled from IDLE afterwards.
- Back-to-back commands: IDLE may consume a new byte in the cycle after the return from SEND_WAIT.

Decomposition:
- Package uart_cmd_pkg holds:
  - the state enum (IDLE, GET_ADDR, GET_DATA, BUS, SEND, SEND_WAIT);
  - the opcode and response constants OP_WR = 0x57, OP_RD = 0x52, RSP_OK = 0x4B, RSP_ERR = 0x3F.
- One sub-module: uart_cmd_txq, the response shift register, byte counter and the SEND/SEND_WAIT pacing with the tx_full handshake.
- Decode, intake and bus control stay in the top.

Test Plan:
- Write: bytes 57 00 01 23 BE EF → exactly one bus cycle with we = 1, addr = 0x000123, wdata = 0xBEEF; ack after 5 cycles → single response byte 0x4B.
- Read: bytes 52 00 00 10, bus_rdata = 0x1234 with ack in the first req cycle → bus_req lasts exactly 1 cycle; response bytes 0x12 then 0x34 in that order.
- Bad opcode: byte 0xA5 → err_pulse for 1 cycle, response 0x3F, no bus_req; a following valid read is serviced normally.
- Timeout (TIMEOUT_CYC = 20): bytes 57 00, then silence → err_pulse after 20 idle cycles, busy = 0, no bus_req, no tx byte; the next full write completes.
- Backpressure: hold tx_full = 1 for 100 cycles during a read response → wr_uart stays 0; after release exactly 2 pulses, at least 2 cycles apart, and never while tx_full = 1.
- Reset mid-BUS: assert rst_n = 0 while bus_req = 1 → bus_req = 0 asynchronously, all outputs 0; a late bus_ack after reset produces no response.
